peak_detector: RTL and testbench

PEAK_DETECTOR -- requirements
Module: peak_detector

---
 rtl/correlator_pkg.sv | 15 +
 rtl/peak_detector.sv | 132 +++++++++++++
 tb/tb_peak_detector.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/correlator_pkg.sv
// Shared parameters and FSM state encoding for the correlator and the peak detector.
package correlator_pkg;

    localparam int unsigned NUM_LAGS_DEF  = 15;
    localparam int unsigned VALUE_W_DEF   = 4;
    localparam int unsigned LAG_W_DEF     = 4;
    localparam int unsigned THRESHOLD_DEF = 5;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/peak_detector.sv
// Tracks the maximum correlation value and its lag across a sweep, then holds
// the result with a valid/ready handshake until the consumer accepts it.
module peak_detector
    import correlator_pkg::*;
#(
    parameter int unsigned NUM_LAGS  = NUM_LAGS_DEF,
    parameter int unsigned VALUE_W   = VALUE_W_DEF,
    parameter int unsigned LAG_W     = LAG_W_DEF,
    parameter int unsigned THRESHOLD = THRESHOLD_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sweep_start,
    input  logic               corr_valid,
    input  logic [VALUE_W-1:0] corr_value,
    input  logic               peak_ready,
    output logic               peak_valid,
    output logic [VALUE_W-1:0] peak_value,
    output logic [LAG_W-1:0]   peak_lag,
    output logic               peak_match,
    output logic               busy,
    output logic [7:0]         sweep_count
);

    state_e             state_q, state_d;
    logic [LAG_W-1:0]   lag_cnt_q, lag_cnt_d;
    logic [LAG_W-1:0]   best_lag_q, best_lag_d;
    logic [VALUE_W-1:0] best_val_q, best_val_d;
    logic [VALUE_W-1:0] peak_value_q, peak_value_d;
    logic [LAG_W-1:0]   peak_lag_q, peak_lag_d;
    logic               peak_match_q, peak_match_d;
    logic [7:0]         sweep_count_q, sweep_count_d;

    logic               take;
    logic               last;
    logic [VALUE_W-1:0] cand_val;
    logic [LAG_W-1:0]   cand_lag;

    // Strict compare so that ties keep the earliest lag.
    always_comb begin
        take     = (lag_cnt_q == '0) || (corr_value > best_val_q);
        cand_val = take ? corr_value : best_val_q;
        cand_lag = take ? lag_cnt_q : best_lag_q;
        last     = (lag_cnt_q == LAG_W'(NUM_LAGS - 1));
    end

    always_comb begin
        state_d       = state_q;
        lag_cnt_d     = lag_cnt_q;
        best_val_d    = best_val_q;
        best_lag_d    = best_lag_q;
        peak_value_d  = peak_value_q;
        peak_lag_d    = peak_lag_q;
        peak_match_d  = peak_match_q;
        sweep_count_d = sweep_count_q;

        case (state_q)
            StIdle: begin
                if (sweep_start) begin
                    state_d    = StAccum;
                    lag_cnt_d  = '0;
                    best_val_d = '0;
                    best_lag_d = '0;
                end
            end
            StAccum: begin
                if (sweep_start) begin
                    lag_cnt_d  = '0;
                    best_val_d = '0;
                    best_lag_d = '0;
                end else if (corr_valid) begin
                    best_val_d = cand_val;
                    best_lag_d = cand_lag;
                    if (last) begin
                        state_d       = StDone;
                        lag_cnt_d     = '0;
                        peak_value_d  = cand_val;
                        peak_lag_d    = cand_lag;
                        peak_match_d  = (32'(cand_val) >= THRESHOLD);
                        sweep_count_d = sweep_count_q + 8'd1;
                    end else begin
                        lag_cnt_d = lag_cnt_q + 1'b1;
                    end
                end
            end
            StDone: begin
                // A start without an accept is dropped so the held result stays intact.
                if (peak_ready) begin
                    if (sweep_start) begin
                        state_d    = StAccum;
                        lag_cnt_d  = '0;
                        best_val_d = '0;
                        best_lag_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            lag_cnt_q     <= '0;
            best_val_q    <= '0;
            best_lag_q    <= '0;
            peak_value_q  <= '0;
            peak_lag_q    <= '0;
            peak_match_q  <= 1'b0;
            sweep_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            lag_cnt_q     <= lag_cnt_d;
            best_val_q    <= best_val_d;
            best_lag_q    <= best_lag_d;
            peak_value_q  <= peak_value_d;
            peak_lag_q    <= peak_lag_d;
            peak_match_q  <= peak_match_d;
            sweep_count_q <= sweep_count_d;
        end
    end

    assign peak_valid  = (state_q == StDone);
    assign busy        = (state_q == StAccum);
    assign peak_value  = peak_value_q;
    assign peak_lag    = peak_lag_q;
    assign peak_match  = peak_match_q;
    assign sweep_count = sweep_count_q;

endmodule

// File: tb/tb_peak_detector.sv
// Directed bench for peak_detector: ramp, ties, threshold edge, restart,
// back-pressure hold, asynchronous reset mid-sweep and sweep counter wrap.
module tb_peak_detector;

    logic       clk;
    logic       reset;
    logic       sweep_start;
    logic       corr_valid;
    logic [3:0] corr_value;
    logic       peak_ready;
    logic       peak_valid;
    logic [3:0] peak_value;
    logic [3:0] peak_lag;
    logic       peak_match;
    logic       busy;
    logic [7:0] sweep_count;

    int tests  = 0;
    int failed = 0;

    peak_detector dut (
        .clk         (clk),
        .reset       (reset),
        .sweep_start (sweep_start),
        .corr_valid  (corr_valid),
        .corr_value  (corr_value),
        .peak_ready  (peak_ready),
        .peak_valid  (peak_valid),
        .peak_value  (peak_value),
        .peak_lag    (peak_lag),
        .peak_match  (peak_match),
        .busy        (busy),
        .sweep_count (sweep_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic start();
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
    endtask

    task automatic sample(input logic [3:0] v);
        corr_valid = 1'b1;
        corr_value = v;
        step();
        corr_valid = 1'b0;
    endtask

    task automatic accept();
        peak_ready = 1'b1;
        step();
        peak_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        tests++;
        if ({peak_valid, peak_value, peak_lag, peak_match, busy, sweep_count} !== 19'd0) begin
            $display("FAIL reset_state: got %b, want all zero",
                     {peak_valid, peak_value, peak_lag, peak_match, busy, sweep_count});
            failed++;
        end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_ramp();
        logic [3:0] ramp [15] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0};
        apply_reset();
        start();
        tests++;
        if (busy !== 1'b1) begin
            $display("FAIL ramp_busy: got %b want 1", busy); failed++;
        end
        for (int i = 0; i < 14; i++) sample(ramp[i]);
        tests++;
        if (peak_valid !== 1'b0) begin
            $display("FAIL ramp_early_valid: got %b want 0", peak_valid); failed++;
        end
        sample(ramp[14]);
        tests++;
        if (peak_valid !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL ramp_valid: valid %b busy %b want 1 0", peak_valid, busy); failed++;
        end
        tests++;
        if (peak_value !== 4'd7 || peak_lag !== 4'd7 || peak_match !== 1'b1
            || sweep_count !== 8'd1) begin
            $display("FAIL ramp_result: val %0d lag %0d match %b cnt %0d want 7 7 1 1",
                     peak_value, peak_lag, peak_match, sweep_count);
            failed++;
        end
        accept();
        tests++;
        if (peak_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL ramp_accept: valid %b busy %b want 0 0", peak_valid, busy); failed++;
        end
    endtask

    task automatic test_ties();
        apply_reset();
        // The sample presented with the start pulse must not count as lag 0.
        corr_valid = 1'b1;
        corr_value = 4'd9;
        start();
        corr_valid = 1'b0;
        for (int i = 0; i < 15; i++) sample(4'd3);
        tests++;
        if (peak_valid !== 1'b1 || peak_value !== 4'd3 || peak_lag !== 4'd0
            || peak_match !== 1'b0) begin
            $display("FAIL ties: valid %b val %0d lag %0d match %b want 1 3 0 0",
                     peak_valid, peak_value, peak_lag, peak_match);
            failed++;
        end
        accept();
    endtask

    task automatic test_threshold();
        apply_reset();
        start();
        for (int i = 0; i < 15; i++) sample((i == 3) ? 4'd5 : 4'd4);
        tests++;
        if (peak_value !== 4'd5 || peak_lag !== 4'd3 || peak_match !== 1'b1) begin
            $display("FAIL thresh_eq: val %0d lag %0d match %b want 5 3 1",
                     peak_value, peak_lag, peak_match);
            failed++;
        end
        accept();
        start();
        for (int i = 0; i < 15; i++) sample((i == 14) ? 4'd4 : 4'd2);
        tests++;
        if (peak_value !== 4'd4 || peak_lag !== 4'd14 || peak_match !== 1'b0
            || sweep_count !== 8'd2) begin
            $display("FAIL thresh_below: val %0d lag %0d match %b cnt %0d want 4 14 0 2",
                     peak_value, peak_lag, peak_match, sweep_count);
            failed++;
        end
        accept();
    endtask

    task automatic test_restart();
        apply_reset();
        start();
        for (int i = 0; i < 6; i++) sample(4'd9);
        start();
        tests++;
        if (busy !== 1'b1 || sweep_count !== 8'd0) begin
            $display("FAIL restart_busy: busy %b cnt %0d want 1 0", busy, sweep_count); failed++;
        end
        for (int i = 0; i < 15; i++) sample((i == 12) ? 4'd8 : 4'd1);
        tests++;
        if (peak_valid !== 1'b1 || peak_value !== 4'd8 || peak_lag !== 4'd12
            || sweep_count !== 8'd1) begin
            $display("FAIL restart_result: valid %b val %0d lag %0d cnt %0d want 1 8 12 1",
                     peak_valid, peak_value, peak_lag, sweep_count);
            failed++;
        end
        accept();
    endtask

    task automatic test_back_to_back();
        logic [3:0] ramp [15] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0};
        apply_reset();
        start();
        for (int i = 0; i < 15; i++) sample(ramp[i]);
        for (int i = 0; i < 10; i++) begin
            sweep_start = i[0];
            corr_valid  = 1'b1;
            corr_value  = 4'd15;
            step();
            tests++;
            if (peak_valid !== 1'b1 || peak_value !== 4'd7 || peak_lag !== 4'd7
                || busy !== 1'b0 || sweep_count !== 8'd1) begin
                $display("FAIL hold_cycle%0d: valid %b val %0d lag %0d busy %b cnt %0d", i,
                         peak_valid, peak_value, peak_lag, busy, sweep_count);
                failed++;
            end
        end
        corr_valid  = 1'b0;
        sweep_start = 1'b1;
        peak_ready  = 1'b1;
        step();
        sweep_start = 1'b0;
        peak_ready  = 1'b0;
        tests++;
        if (busy !== 1'b1 || peak_valid !== 1'b0) begin
            $display("FAIL ready_start: busy %b valid %b want 1 0", busy, peak_valid); failed++;
        end
        for (int i = 0; i < 15; i++) sample(4'd1);
        tests++;
        if (peak_value !== 4'd1 || peak_lag !== 4'd0 || sweep_count !== 8'd2) begin
            $display("FAIL b2b_result: val %0d lag %0d cnt %0d want 1 0 2",
                     peak_value, peak_lag, sweep_count);
            failed++;
        end
        accept();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        start();
        for (int i = 0; i < 15; i++) sample(4'd7);
        accept();
        start();
        for (int i = 0; i < 9; i++) sample(4'(i + 1));
        reset = 1'b1;
        #1;
        tests++;
        if ({peak_valid, peak_value, peak_lag, peak_match, busy, sweep_count} !== 19'd0) begin
            $display("FAIL reset_mid: got %b want all zero",
                     {peak_valid, peak_value, peak_lag, peak_match, busy, sweep_count});
            failed++;
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sample(4'd9);
            tests++;
            if (peak_valid !== 1'b0 || busy !== 1'b0) begin
                $display("FAIL no_start_%0d: valid %b busy %b want 0 0", i, peak_valid, busy);
                failed++;
            end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int s = 1; s <= 256; s++) begin
            start();
            for (int i = 0; i < 15; i++) sample(4'(i));
            if (s == 255 || s == 256) begin
                tests++;
                if (peak_valid !== 1'b1 || sweep_count !== 8'(s)) begin
                    $display("FAIL wrap_%0d: valid %b cnt %0d want 1 %0d",
                             s, peak_valid, sweep_count, s % 256);
                    failed++;
                end
            end
            accept();
        end
    endtask

    initial begin
        reset       = 1'b1;
        sweep_start = 1'b0;
        corr_valid  = 1'b0;
        corr_value  = 4'd0;
        peak_ready  = 1'b0;
        test_reset();
        test_ramp();
        test_ties();
        test_threshold();
        test_restart();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
